alu_cc_unit: RTL

Execute-stage block that consumes the register file's SR1OUT/SR2OUT read ports. It performs the LC-3 ALU operation, with the second operand selected by SR2MUX. It drives the ALU result toward the bus gate. It also holds the NZP condition-code register, loaded from the bus, and the BEN branch-enable register used by the control FSM.

---
 rtl/alu_cc_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/alu_cc_unit.sv
// ----------------------------------------------------------------------------
// alu_cc_unit
//
// This is the LC-3 execute-stage ALU, together with the condition-code and
// branch-enable state.
//
//   Clk     : system clock. All state updates happen on the rising edge.
//   Reset   : synchronous, active-high. Clears NZP and BEN.
//   SR1OUT  : operand A from the register file SR1 port.
//   SR2OUT  : operand B from the register file SR2 port.
//   IR      : instruction register. IR[4:0] holds imm5 and IR[11:9] holds
//             the branch nzp mask.
//   SR2MUX  : 0 selects SR2OUT as B. 1 selects SEXT(IR[4:0]) as B.
//   ALUK    : 00 ADD, 01 AND, 10 NOT A, 11 PASS A.
//   bus     : CPU bus. It is sampled into NZP only when LD_CC is high.
//   LD_CC   : load NZP from the bus.
//   LD_BEN  : load BEN from IR[11:9] and the current NZP.
//   ALU     : combinational ALU result with zero latency.
//   NZP     : registered condition codes {N,Z,P}.
//   BEN     : registered branch enable.
// ----------------------------------------------------------------------------
module alu_cc_unit #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SR1OUT,
    input  logic [WIDTH-1:0] SR2OUT,
    input  logic [WIDTH-1:0] IR,
    input  logic             SR2MUX,
    input  logic [1:0]       ALUK,
    input  logic [WIDTH-1:0] bus,
    input  logic             LD_CC,
    input  logic             LD_BEN,
    output logic [WIDTH-1:0] ALU,
    output logic [2:0]       NZP,
    output logic             BEN
);

    logic signed [WIDTH-1:0] opa;
    logic signed [WIDTH-1:0] opb;
    logic signed [WIDTH-1:0] imm5_sext;

    // Classify a bus value into a one-hot {N,Z,P} code.
    function automatic logic [2:0] cc_of(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1])
            cc_of = 3'b100;
        else if (v == '0)
            cc_of = 3'b010;
        else
            cc_of = 3'b001;
    endfunction

    // Perform the ALU operation. The ADD wraps modulo 2^WIDTH because the
    // result width matches the operand width.
    function automatic logic [WIDTH-1:0] alu_op(
        input logic [1:0]              k,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        case (k)
            2'b00:   alu_op = a + b;
            2'b01:   alu_op = a & b;
            2'b10:   alu_op = ~a;
            default: alu_op = a;
        endcase
    endfunction

    // Combinational operand select and ALU
    assign imm5_sext = {{(WIDTH-5){IR[4]}}, IR[4:0]};
    assign opa       = SR1OUT;
    assign opb       = SR2MUX ? imm5_sext : SR2OUT;
    assign ALU       = alu_op(ALUK, opa, opb);

    // Registered condition codes and branch enable. BEN samples the NZP value
    // from before this edge, even when NZP is being loaded on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            NZP <= 3'b000;
            BEN <= 1'b0;
        end else begin
            if (LD_CC)
                NZP <= cc_of(bus);
            if (LD_BEN)
                BEN <= |(IR[11:9] & NZP);
        end
    end

endmodule
